// File: rtl/muldiv_seq_if.sv
// Operation handshake and result bus of the sequential multiply/divide unit.
// The sequencer side is the master, the arithmetic unit the slave.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             ce;
  logic             start;
  logic             abort;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             dz;
  logic             ov;

  modport master (output ce, start, abort, op, a, b,
                  input  busy, done, lo, hi, dz, ov);
  modport slave  (input  ce, start, abort, op, a, b,
                  output busy, done, lo, hi, dz, ov);
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULU/MULS/DIVU/DIVS unit: operates on magnitudes, one bit per cycle
// for division (and optionally multiplication), then fixes signs in a final state.
module muldiv_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_p;
  logic             r_ov_p;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out_lo;
  logic [WIDTH-1:0] r_out_hi;
  logic             r_dz;
  logic             r_ov;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_b_zero;
  logic               w_div_ovf;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_acc_neg;
  logic [WIDTH-1:0]   w_lo_neg;
  logic [WIDTH-1:0]   w_hi_neg;

  assign w_a_neg   = bus.op[0] & bus.a[WIDTH-1];
  assign w_b_neg   = bus.op[0] & bus.b[WIDTH-1];
  assign w_mag_a   = w_a_neg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
  assign w_mag_b   = w_b_neg ? ({WIDTH{1'b0}} - bus.b) : bus.b;
  assign w_prod    = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
  assign w_b_zero  = (bus.b == {WIDTH{1'b0}});
  assign w_div_ovf = (bus.op == 2'b11) && (bus.a == MIN_VAL) && (bus.b == {WIDTH{1'b1}});

  // Partial remainder keeps the bit shifted out of rem so large unsigned divisors compare correctly.
  assign w_partial = {r_hi, r_lo[WIDTH-1]};
  assign w_diff    = w_partial - {1'b0, r_dvs};
  assign w_ge      = (w_partial >= {1'b0, r_dvs});
  assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : {(WIDTH+1){1'b0}});

  assign w_acc     = {r_hi, r_lo};
  assign w_acc_neg = {(2*WIDTH){1'b0}} - w_acc;
  assign w_lo_neg  = {WIDTH{1'b0}} - r_lo;
  assign w_hi_neg  = {WIDTH{1'b0}} - r_hi;

  // Control FSM, datapath iteration and registered result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz_p   <= 1'b0;
      r_ov_p   <= 1'b0;
      r_dvs    <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out_lo <= {WIDTH{1'b0}};
      r_out_hi <= {WIDTH{1'b0}};
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
    end else if (bus.ce) begin
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_is_div <= bus.op[1];
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_dz_p   <= 1'b0;
              r_ov_p   <= 1'b0;
              r_cnt    <= {CW{1'b0}};
              r_busy   <= 1'b1;
              r_hi     <= {WIDTH{1'b0}};
              r_dvs    <= bus.op[1] ? w_mag_b : w_mag_a;
              r_lo     <= bus.op[1] ? w_mag_a : w_mag_b;
              r_state  <= S_RUN;
              // Special results are preloaded unsigned so FIX passes them through.
              if (bus.op[1] && w_b_zero) begin
                r_lo    <= {WIDTH{1'b1}};
                r_hi    <= bus.a;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_dz_p  <= 1'b1;
                r_state <= S_FIX;
              end else if (w_div_ovf) begin
                r_lo    <= MIN_VAL;
                r_hi    <= {WIDTH{1'b0}};
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_ov_p  <= 1'b1;
                r_state <= S_FIX;
              end else if (!bus.op[1] && (MUL_ITER == 0)) begin
                {r_hi, r_lo} <= w_prod;
                r_state      <= S_FIX;
              end else begin
                r_state <= S_RUN;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_RUN: begin
            if (r_is_div) begin
              r_hi <= w_ge ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_RUN;
            end
          end
          S_FIX: begin
            if (r_is_div) begin
              r_out_lo <= r_neg_q ? w_lo_neg : r_lo;
              r_out_hi <= r_neg_r ? w_hi_neg : r_hi;
            end else begin
              {r_out_hi, r_out_lo} <= r_neg_q ? w_acc_neg : w_acc;
            end
            r_dz    <= r_dz_p;
            r_ov    <= r_ov_p;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.lo   = r_out_lo;
  assign bus.hi   = r_out_hi;
  assign bus.dz   = r_dz;
  assign bus.ov   = r_ov;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench: drives a combinational-multiply and an iterative-multiply
// instance with identical stimulus and checks results and latency against a model.
module tb_muldiv_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    logic         ov;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         ce, start, abort;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           busy_seen = 0;
  logic         pd_c = 1'b0;
  logic         pd_i = 1'b0;
  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;
  exp_t         q_c[$];
  exp_t         q_i[$];

  muldiv_seq_if #(.WIDTH(W)) if_c ();
  muldiv_seq_if #(.WIDTH(W)) if_i ();

  assign if_c.ce = ce;  assign if_c.start = start;  assign if_c.abort = abort;
  assign if_c.op = op;  assign if_c.a = a;          assign if_c.b = b;
  assign if_i.ce = ce;  assign if_i.start = start;  assign if_i.abort = abort;
  assign if_i.op = op;  assign if_i.a = a;          assign if_i.b = b;

  muldiv_seq #(.WIDTH(W), .MUL_ITER(0)) u_dut_c (.clock(clk), .reset_n(rst_n), .bus(if_c));
  muldiv_seq #(.WIDTH(W), .MUL_ITER(1)) u_dut_i (.clock(clk), .reset_n(rst_n), .bus(if_i));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    e.dz = 1'b0; e.ov = 1'b0; e.due = 0; p = 64'd0;
    case (o)
      2'b00: p = {32'd0, x} * {32'd0, y};
      2'b01: p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      default: p = 64'd0;
    endcase
    e.lo = p[31:0];
    e.hi = p[63:32];
    if (o[1]) begin
      if (y == 32'd0) begin
        e.lo = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
      end else if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 32'd0; e.ov = 1'b1;
      end else if (o[0]) begin
        e.lo = 32'($signed(x) / $signed(y));
        e.hi = 32'($signed(x) % $signed(y));
      end else begin
        e.lo = x / y;
        e.hi = x % y;
      end
    end
    return e;
  endfunction

  task automatic on_done(input int which, input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic dz, input logic ov);
    exp_t e;
    if ((which == 0 && q_c.size() == 0) || (which == 1 && q_i.size() == 0)) begin
      check(which == 0 ? "c_spurious_done" : "i_spurious_done", 64'd1, 64'd0);
    end else begin
      if (which == 0) e = q_c.pop_front();
      else            e = q_i.pop_front();
      check(which == 0 ? "c_lo" : "i_lo", lo, e.lo);
      check(which == 0 ? "c_hi" : "i_hi", hi, e.hi);
      check(which == 0 ? "c_dz" : "i_dz", dz, e.dz);
      check(which == 0 ? "c_ov" : "i_ov", ov, e.ov);
      check(which == 0 ? "c_latency" : "i_latency", cyc, e.due);
      if (which == 0) begin
        last_lo = e.lo;
        last_hi = e.hi;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && if_c.done && !pd_c) on_done(0, if_c.lo, if_c.hi, if_c.dz, if_c.ov);
    if (rst_n && if_i.done && !pd_i) on_done(1, if_i.lo, if_i.hi, if_i.dz, if_i.ov);
    pd_c <= if_c.done;
    pd_i <= if_i.done;
  end

  // Called at a falling edge; start is accepted on the following rising edge.
  task automatic drive(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int extra, input bit push);
    exp_t e;
    int lat_c, lat_i;
    e = model(o, x, y);
    if (o[1]) begin
      lat_c = (e.dz || e.ov) ? 1 : W + 1;
      lat_i = lat_c;
    end else begin
      lat_c = 1;
      lat_i = W + 1;
    end
    if (push) begin
      e.due = cyc + 1 + lat_c + extra; q_c.push_back(e);
      e.due = cyc + 1 + lat_i + extra; q_i.push_back(e);
    end
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    busy_seen = if_c.busy ? 1 : 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_c.size() != 0 || q_i.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (if_c.busy) busy_seen++;
    end
    if (q_c.size() != 0 || q_i.size() != 0) begin
      check("timeout", 64'd1, 64'd0);
      q_c.delete();
      q_i.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
    #3;
    check("rst_busy", if_c.busy, 1'b0);
    check("rst_done", if_c.done, 1'b0);
    check("rst_lo", if_c.lo, 32'd0);
    check("rst_hi", if_c.hi, 32'd0);
    check("rst_dz", if_c.dz, 1'b0);
    check("rst_ov", if_c.ov, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive(2'b10, 32'd100, 32'd7, 0, 1'b1);
    wait_idle();
    check("divu_busy_cycles", busy_seen, 33);

    drive(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);          wait_idle();
    drive(2'b11, 32'd7, 32'hFFFF_FFFE, 0, 1'b1);          wait_idle();
    drive(2'b10, 32'h1234, 32'd0, 0, 1'b1);               wait_idle();
    drive(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);  wait_idle();
    drive(2'b11, 32'hFFFF_FF00, 32'd0, 0, 1'b1);          wait_idle();
    drive(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 1'b1);          wait_idle();
    drive(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);  wait_idle();
    drive(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b1);  wait_idle();
    for (int i = 0; i < 8; i++) begin
      drive(2'(i), $urandom, (i == 5) ? 32'd3 : $urandom, 0, 1'b1);
      wait_idle();
    end

    // Back-to-back: second start lands in the done cycle of the first.
    drive(2'b10, 32'd50, 32'd5, 0, 1'b1);
    for (int n = 0; n < 60 && !if_c.done; n++) @(negedge clk);
    check("b2b_done_seen", if_c.done, 1'b1);
    drive(2'b10, 32'd81, 32'd9, 0, 1'b1);
    wait_idle();

    // Stall mid-run for 5 cycles, with an ignored start while busy.
    drive(2'b10, 32'd1000, 32'd10, 5, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    ce = 1'b0;
    repeat (5) @(negedge clk);
    ce = 1'b1;
    wait_idle();

    // Abort at iteration 10: no done, results keep their previous values.
    drive(2'b10, 32'd500, 32'd3, 0, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_busy_c", if_c.busy, 1'b0);
    check("abort_busy_i", if_i.busy, 1'b0);
    repeat (40) @(negedge clk);
    check("abort_lo", if_c.lo, last_lo);
    check("abort_hi", if_c.hi, last_hi);
    check("abort_lo_i", if_i.lo, last_lo);

    // Asynchronous reset between edges while running.
    drive(2'b10, 32'd1000, 32'd7, 0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", if_c.busy, 1'b0);
    check("arst_done", if_c.done, 1'b0);
    check("arst_lo", if_c.lo, 32'd0);
    check("arst_hi", if_c.hi, 32'd0);
    check("arst_dz", if_c.dz, 1'b0);
    check("arst_ov", if_c.ov, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(2'b10, 32'd9, 32'd3, 0, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
